// File: rtl/dc_bu_line_reader.sv
// Line reader for the buffering-unit line memory: reads one line of words and streams them out over valid/ready.
// Latency: first pixel valid 2 cycles after an accepted start. After that, one pixel per cycle when m_ready stays high.
// Backpressure: at most 2 words are in flight or buffered. Reads pause while that limit is reached.
//
// Optional build macro: DC_BU_READER_REPEAT_EN. When defined it adds the h_rep port,
// and each word is emitted h_rep+1 times in a row.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start, base_addr, line_len  line request (ignored while busy)
//   h_rep                       repeat count minus one (macro build only)
//   busy, done                  line in progress / one-cycle completion pulse
//   mem_ce, mem_re, mem_raddr   memory read port
//   mem_we                      memory write strobe (a write blocks the read that cycle)
//   mem_rdata                   registered read data (1-cycle latency)
//   m_valid, m_data, m_last     output pixel stream
//   m_ready                     downstream ready
module dc_bu_line_reader #(
    parameter int BUFF_ADDR_WIDTH = 10,
    parameter int MEMORY_HEIGHT   = 128,
    parameter int WORD_WIDTH      = 24,
    parameter int REP_WIDTH       = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [BUFF_ADDR_WIDTH-1:0] base_addr,
    input  logic [BUFF_ADDR_WIDTH-1:0] line_len,
`ifdef DC_BU_READER_REPEAT_EN
    input  logic [REP_WIDTH-1:0]       h_rep,
`endif
    output logic                       busy,
    output logic                       done,
    output logic                       mem_ce,
    output logic                       mem_re,
    output logic [BUFF_ADDR_WIDTH-1:0] mem_raddr,
    input  logic                       mem_we,
    input  logic [WORD_WIDTH-1:0]      mem_rdata,
    output logic                       m_valid,
    output logic [WORD_WIDTH-1:0]      m_data,
    output logic                       m_last,
    input  logic                       m_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic                       done_nxt;
    logic [BUFF_ADDR_WIDTH-1:0] rd_left;
    logic [BUFF_ADDR_WIDTH-1:0] raddr_inc;
    logic                       rd_accept;
    logic                       inflight;
    logic                       inflight_last;

    // Two-entry skid FIFO. The top bit of each entry marks the final word of the line.
    logic [WORD_WIDTH:0]        fifo_q0;
    logic [WORD_WIDTH:0]        fifo_q1;
    logic [WORD_WIDTH:0]        head;
    logic                       rd_ptr;
    logic                       wr_ptr;
    logic [1:0]                 fifo_count;
    logic [1:0]                 occ_after_pop;
    logic [2:0]                 committed;
    logic                       push;
    logic                       pop;
    logic                       last_pop;

    logic [REP_WIDTH-1:0]       rep_in;
    logic [REP_WIDTH-1:0]       rep_q;
    logic [REP_WIDTH-1:0]       rep_cnt;
    logic                       rep_done;

`ifdef DC_BU_READER_REPEAT_EN
    assign rep_in = h_rep;
`else
    // Without repeat, every word is its own final repetition.
    assign rep_in = '0;
`endif

    assign head     = rd_ptr ? fifo_q1 : fifo_q0;
    assign m_valid  = (fifo_count != 2'd0);
    assign m_data   = head[WORD_WIDTH-1:0];
    assign rep_done = (rep_cnt == rep_q);
    assign m_last   = m_valid && head[WORD_WIDTH] && rep_done;
    // A FIFO entry is freed only when its last repetition is handed off.
    assign pop      = m_valid && m_ready && rep_done;
    assign last_pop = pop && head[WORD_WIDTH];
    assign push     = inflight;

    // Count the entry being popped this cycle as already free.
    // Without this, the output would stall one cycle in two at full rate.
    assign occ_after_pop = fifo_count - {1'b0, pop};
    assign committed     = {1'b0, occ_after_pop} + {2'b00, inflight};

    assign rd_accept = mem_re && !mem_we;
    assign mem_ce    = mem_re;
    assign busy      = (state != IDLE);

    // A base address past the end wraps here on its first increment.
    assign raddr_inc = (mem_raddr >= BUFF_ADDR_WIDTH'(MEMORY_HEIGHT - 1))
                       ? '0 : mem_raddr + BUFF_ADDR_WIDTH'(1);

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        mem_re    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (line_len == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = READ;
                    end
                end
            end
            READ: begin
                mem_re = (committed < 3'd2);
                if (mem_re && !mem_we && (rd_left == BUFF_ADDR_WIDTH'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            done          <= 1'b0;
            mem_raddr     <= '0;
            rd_left       <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            fifo_q0       <= '0;
            fifo_q1       <= '0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            fifo_count    <= 2'd0;
            rep_q         <= '0;
            rep_cnt       <= '0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;

            if (state == IDLE && start) begin
                mem_raddr <= base_addr;
                rd_left   <= line_len;
                rep_q     <= rep_in;
            end else if (rd_accept) begin
                mem_raddr <= raddr_inc;
                rd_left   <= rd_left - BUFF_ADDR_WIDTH'(1);
            end

            // Read data appears on mem_rdata exactly one cycle after an accepted read.
            inflight      <= rd_accept;
            inflight_last <= rd_accept && (rd_left == BUFF_ADDR_WIDTH'(1));

            if (push) begin
                if (wr_ptr) begin
                    fifo_q1 <= {inflight_last, mem_rdata};
                end else begin
                    fifo_q0 <= {inflight_last, mem_rdata};
                end
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= occ_after_pop + {1'b0, push};

            if (m_valid && m_ready) begin
                rep_cnt <= rep_done ? '0 : rep_cnt + REP_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_dc_bu_line_reader.sv
module tb_dc_bu_line_reader;
    localparam int AW = 10;
    localparam int MH = 128;
    localparam int WW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] line_len;
`ifdef DC_BU_READER_REPEAT_EN
    logic [2:0]    h_rep;
`endif
    logic          busy;
    logic          done;
    logic          mem_ce;
    logic          mem_re;
    logic [AW-1:0] mem_raddr;
    logic          mem_we;
    logic [WW-1:0] mem_rdata;
    logic          m_valid;
    logic [WW-1:0] m_data;
    logic          m_last;
    logic          m_ready = 1'b1;

    always #5 clk = ~clk;

    dc_bu_line_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .line_len  (line_len),
`ifdef DC_BU_READER_REPEAT_EN
        .h_rep     (h_rep),
`endif
        .busy      (busy),
        .done      (done),
        .mem_ce    (mem_ce),
        .mem_re    (mem_re),
        .mem_raddr (mem_raddr),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_ready   (m_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Line memory contents and a registered read port with 1-cycle latency.
    logic [WW-1:0] mem [MH];
    always @(posedge clk) begin : mem_model
        bit      take;
        int      a;
        take = mem_re && !mem_we;
        a    = int'(mem_raddr) % MH;
        #1;
        if (take) mem_rdata = mem[a];
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    // 0: m_ready held high, 1: m_ready toggles every cycle.
    int ready_mode = 0;
    always @(posedge clk) begin
        #1;
        m_ready = (ready_mode == 1) ? ~m_ready : 1'b1;
    end

    // Reference model: expected pixel stream, expected read addresses, busy/done.
    bit            m_busy = 0;
    bit            m_done = 0;
    logic [WW-1:0] exp_data [$];
    bit            exp_wend [$];
    int            exp_addr [$];
    int            rd_acc = 0;
    int            words_done = 0;
    bit            prev_stall = 0;
    logic [WW-1:0] prev_data;
    logic          prev_last;

    // Logs used by the hand-computed checks.
    logic [WW-1:0] hs_data [$];
    int            hs_cyc [$];
    int            raddr_log [$];
    int            start_cyc = 0;
    int            done_cyc = 0;
    int            done_cnt = 0;

    always @(negedge clk) begin : compare
        bit last_hs;
        bit nb;
        bit nd;
        int r;
        int a;
        if (rst) begin
            m_busy = 0;
            m_done = 0;
            exp_data.delete();
            exp_wend.delete();
            exp_addr.delete();
            rd_acc = 0;
            words_done = 0;
            prev_stall = 0;
        end else begin
            last_hs = 0;
            chk_eq("busy", busy, m_busy);
            chk_eq("done", done, m_done);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            chk_eq("mem_ce", mem_ce, mem_re);
            if (!m_busy) chk_eq("re_when_idle", mem_re, 0);
            if (!m_valid) chk_eq("last_without_valid", m_last, 0);
            if (prev_stall) begin
                chk_eq("stall_valid", m_valid, 1);
                chk_eq("stall_data", m_data, prev_data);
                chk_eq("stall_last", m_last, prev_last);
            end
            if (mem_re && !mem_we) begin
                raddr_log.push_back(int'(mem_raddr));
                chk_eq("read_expected", exp_addr.size() > 0, 1);
                if (exp_addr.size() > 0) begin
                    chk_eq("raddr", mem_raddr, exp_addr.pop_front());
                    rd_acc++;
                end
            end
            if (m_valid && m_ready) begin
                hs_data.push_back(m_data);
                hs_cyc.push_back(cyc);
                chk_eq("pixel_expected", exp_data.size() > 0, 1);
                if (exp_data.size() > 0) begin
                    chk_eq("m_data", m_data, exp_data.pop_front());
                    chk_eq("m_last", m_last, exp_data.size() == 0);
                    if (exp_wend.pop_front()) words_done++;
                    if (exp_data.size() == 0) last_hs = 1;
                end
            end
            chk_eq("outstanding_le_2", (rd_acc - words_done) <= 2, 1);
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;

            nb = m_busy;
            nd = 0;
            if (last_hs) begin
                nb = 0;
                nd = 1;
            end
            if (start && !m_busy) begin
                start_cyc = cyc;
`ifdef DC_BU_READER_REPEAT_EN
                r = int'(h_rep);
`else
                r = 0;
`endif
                if (line_len == '0) begin
                    nd = 1;
                end else begin
                    nb = 1;
                    for (int i = 0; i < int'(line_len); i++) begin
                        a = (int'(base_addr) + i) % MH;
                        for (int k = 0; k <= r; k++) begin
                            exp_data.push_back(mem[a]);
                            exp_wend.push_back(k == r);
                        end
                        exp_addr.push_back(a);
                    end
                end
            end
            m_busy = nb;
            m_done = nd;
        end
    end

    task automatic clear_logs();
        hs_data.delete();
        hs_cyc.delete();
        raddr_log.delete();
    endtask

    task automatic start_line(input int b, input int l);
        base_addr = AW'(b);
        line_len  = AW'(l);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_line();
        int  d0;
        bit  seen;
        d0   = done_cnt;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            if (done_cnt != d0) seen = 1;
        end
        chk_eq("line_done_timeout", seen, 1);
        #1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int dstart;
        for (int i = 0; i < MH; i++) mem[i] = WW'(i * 32'h010203 + 32'h0A0B0C);
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        line_len  = '0;
        mem_we    = 1'b0;
        mem_rdata = '0;
`ifdef DC_BU_READER_REPEAT_EN
        h_rep     = '0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_done", done, 0);
        chk_eq("rst_mem_re", mem_re, 0);
        chk_eq("rst_mem_ce", mem_ce, 0);
        chk_eq("rst_raddr", mem_raddr, 0);
        chk_eq("rst_m_valid", m_valid, 0);
        chk_eq("rst_m_last", m_last, 0);
        chk_eq("rst_m_data", m_data, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic line: four consecutive pixels, first one 3 sampled cycles after start.
        clear_logs();
        start_line(0, 4);
        wait_line();
        chk_eq("basic_npix", hs_data.size(), 4);
        chk_eq("basic_pix0", hs_data[0], 24'h0A0B0C);
        chk_eq("basic_pix1", hs_data[1], 24'h0B0D0F);
        chk_eq("basic_pix2", hs_data[2], 24'h0C0F12);
        chk_eq("basic_pix3", hs_data[3], 24'h0D1115);
        chk_eq("basic_first_lat", hs_cyc[0] - start_cyc, 3);
        chk_eq("basic_last_lat", hs_cyc[3] - start_cyc, 6);
        chk_eq("basic_done_lat", done_cyc - start_cyc, 7);

        // Address wrap at the end of the memory.
        clear_logs();
        start_line(126, 4);
        wait_line();
        chk_eq("wrap_nreads", raddr_log.size(), 4);
        chk_eq("wrap_addr0", raddr_log[0], 126);
        chk_eq("wrap_addr1", raddr_log[1], 127);
        chk_eq("wrap_addr2", raddr_log[2], 0);
        chk_eq("wrap_addr3", raddr_log[3], 1);
        chk_eq("wrap_pix0", hs_data[0], 24'h890886);

        // Write collision on the second read: that read is retried and one bubble appears.
        clear_logs();
        start_line(0, 4);
        @(posedge clk);
        #1 mem_we = 1'b1;
        @(posedge clk);
        #1 mem_we = 1'b0;
        wait_line();
        chk_eq("coll_addr1", raddr_log[1], 1);
        chk_eq("coll_addr2", raddr_log[2], 2);
        chk_eq("coll_pix1", hs_data[1], 24'h0B0D0F);
        chk_eq("coll_span", hs_cyc[3] - hs_cyc[0], 4);
        chk_eq("coll_done_lat", done_cyc - start_cyc, 8);

        // Backpressure: m_ready toggles every cycle.
        clear_logs();
        ready_mode = 1;
        start_line(20, 8);
        wait_line();
        ready_mode = 0;
        chk_eq("bp_npix", hs_data.size(), 8);
        chk_eq("bp_pix0", hs_data[0], 24'h1E3348);
        chk_eq("bp_pix7", hs_data[7], 24'h25415D);
        @(posedge clk);
        #1;

        // Zero-length line: done on the next cycle, no reads.
        clear_logs();
        start_line(5, 0);
        wait_line();
        chk_eq("len0_done_lat", done_cyc - start_cyc, 1);
        chk_eq("len0_nreads", raddr_log.size(), 0);

        // A start pulse while busy is ignored.
        clear_logs();
        dstart = done_cnt;
        start_line(40, 4);
        start_line(60, 2);
        wait_line();
        repeat (6) @(posedge clk);
        #1;
        chk_eq("busy_start_npix", hs_data.size(), 4);
        chk_eq("busy_start_pix0", hs_data[0], 24'h325B84);
        chk_eq("busy_start_ndone", done_cnt - dstart, 1);

        // Reset mid-line: outputs clear, no done pulse, the next line runs normally.
        clear_logs();
        dstart = done_cnt;
        start_line(10, 8);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk_eq("mid_rst_busy", busy, 0);
        chk_eq("mid_rst_done", done, 0);
        chk_eq("mid_rst_valid", m_valid, 0);
        chk_eq("mid_rst_last", m_last, 0);
        chk_eq("mid_rst_data", m_data, 0);
        chk_eq("mid_rst_re", mem_re, 0);
        chk_eq("mid_rst_raddr", mem_raddr, 0);
        repeat (6) @(posedge clk);
        #1;
        chk_eq("mid_rst_no_done", done_cnt - dstart, 0);
        clear_logs();
        start_line(3, 3);
        wait_line();
        chk_eq("after_rst_npix", hs_data.size(), 3);

`ifdef DC_BU_READER_REPEAT_EN
        // Horizontal repeat: each word is emitted three times.
        clear_logs();
        h_rep = 3'd2;
        start_line(0, 2);
        h_rep = 3'd0;
        wait_line();
        chk_eq("rep_npix", hs_data.size(), 6);
        chk_eq("rep_pix2", hs_data[2], 24'h0A0B0C);
        chk_eq("rep_pix3", hs_data[3], 24'h0B0D0F);
        chk_eq("rep_nreads", raddr_log.size(), 2);
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
